// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: hex glyph constants (active low, a..g),
// capture FSM state encoding and the pattern-to-nibble decode function.
package seg7_pkg;

    // Index 0..6 = segment a..g; a lit segment reads as 0.
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        CAPT_LO = 2'd0,
        CAPT_HI = 2'd1,
        PRESENT = 2'd2
    } state_t;

    typedef struct packed {
        logic       invalid;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

    // Inverse of the display decoder; blank and unknown glyphs are flagged.
    function automatic seg_dec_t seg7_to_nibble(input seg_t pat);
        seg_dec_t d;
        d = '{invalid: 1'b0, blank: 1'b0, nibble: 4'h0};
        case (pat)
            SEG_0:     d.nibble = 4'h0;
            SEG_1:     d.nibble = 4'h1;
            SEG_2:     d.nibble = 4'h2;
            SEG_3:     d.nibble = 4'h3;
            SEG_4:     d.nibble = 4'h4;
            SEG_5:     d.nibble = 4'h5;
            SEG_6:     d.nibble = 4'h6;
            SEG_7:     d.nibble = 4'h7;
            SEG_8:     d.nibble = 4'h8;
            SEG_9:     d.nibble = 4'h9;
            SEG_A:     d.nibble = 4'hA;
            SEG_B:     d.nibble = 4'hB;
            SEG_C:     d.nibble = 4'hC;
            SEG_D:     d.nibble = 4'hD;
            SEG_E:     d.nibble = 4'hE;
            SEG_F:     d.nibble = 4'hF;
            SEG_BLANK: d.blank  = 1'b1;
            default:   d.invalid = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_pattern_reader_if.sv
// Byte output handshake of the pattern reader: DATA qualified by VALID,
// consumed when VALID and READY are both high at a clock edge.
interface seg7_pattern_reader_if;
    logic [7:0] DATA;
    logic       VALID;
    logic       READY;

    modport master (output DATA, output VALID, input READY);
    modport slave  (input DATA, input VALID, output READY);
endinterface

// File: rtl/seg7_stable_filter.sv
// Two-flop synchroniser on {segments, digit select} followed by a stability
// counter that emits one accept pulse per stable episode, together with the
// accepted pattern held alongside the pulse.
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  seg_t seg_i,
    input  logic sel_i,
    output logic accept_o,
    output seg_t seg_o,
    output logic sel_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             same, fire;
    logic             accept_q;
    seg_t             acc_seg_q;
    logic             acc_sel_q;

    // Counter clears when the synced value is about to change, otherwise
    // counts up and saturates so a long hold never re-fires.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        cnt_d = cnt_q;
        same  = (sync1_q == sync2_q);
        fire  = same && (cnt_q == CNT_FIRE);
        if (!same)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Synchroniser, counter and registered accept pulse with its pattern.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled at the clock edge (synchronous), and all
        // state updates use non-blocking assignments.
        if (!rst_ni) begin
            sync1_q   <= {SEG_BLANK, 1'b0};
            sync2_q   <= {SEG_BLANK, 1'b0};
            cnt_q     <= '0;
            accept_q  <= 1'b0;
            acc_seg_q <= SEG_BLANK;
            acc_sel_q <= 1'b0;
        end else begin
            sync1_q  <= {seg_i, sel_i};
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            accept_q <= fire;
            if (fire) begin
                acc_seg_q <= sync2_q[7:1];
                acc_sel_q <= sync2_q[0];
            end
        end
    end

    assign accept_o = accept_q;
    assign seg_o    = acc_seg_q;
    assign sel_o    = acc_sel_q;

endmodule

// File: rtl/seg7_pattern_reader.sv
// Reads back two hex digits from a multiplexed active-low 7-segment bus and
// presents them as one byte {HEX1, HEX0} on a valid/ready handshake.
module seg7_pattern_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                          CLOCK_50,
    input  logic                          Resetn,
    input  seg_t                          SEG_IN,
    input  logic                          DIG_SEL,
    input  logic                          ERR_CLR,
    output logic                          ERR,
    seg7_pattern_reader_if.master         out_if
);

    logic     accept;
    seg_t     acc_seg;
    logic     acc_sel;
    seg_dec_t dec;
    logic     hex_ok;

    state_t     state_q;
    logic [3:0] lo_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       err_q;

    seg7_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_filter (
        .clk_i    (CLOCK_50),
        .rst_ni   (Resetn),
        .seg_i    (SEG_IN),
        .sel_i    (DIG_SEL),
        .accept_o (accept),
        .seg_o    (acc_seg),
        .sel_o    (acc_sel)
    );

    assign dec    = seg7_to_nibble(acc_seg);
    assign hex_ok = accept && !dec.invalid && !dec.blank;

    // Capture FSM, nibble/byte registers and sticky error flag.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q <= CAPT_LO;
            lo_q    <= 4'h0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // A new error outranks a simultaneous clear.
            if (accept && dec.invalid)
                err_q <= 1'b1;
            else if (ERR_CLR)
                err_q <= 1'b0;

            case (state_q)
                CAPT_LO: begin
                    if (hex_ok && !acc_sel) begin
                        lo_q    <= dec.nibble;
                        state_q <= CAPT_HI;
                    end
                end
                CAPT_HI: begin
                    if (hex_ok && acc_sel) begin
                        data_q  <= {dec.nibble, lo_q};
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end else if (hex_ok) begin
                        lo_q <= dec.nibble;
                    end
                end
                PRESENT: begin
                    // Byte is held untouched until the consumer takes it.
                    if (valid_q && out_if.READY) begin
                        valid_q <= 1'b0;
                        state_q <= CAPT_LO;
                    end
                end
                default: state_q <= CAPT_LO;
            endcase
        end
    end

    assign out_if.DATA  = data_q;
    assign out_if.VALID = valid_q;
    assign ERR          = err_q;

endmodule
